// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared register file widths and types
package regfile_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, grant combinational, pointer moves past the winner
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  input  logic         advance
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  // Search starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (run && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx[PW-1:0];
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = gnt_idx + 1'b1;
    if (gnt_idx == PW'(N-1)) ptr_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (run && advance) begin
      ptr <= ptr_nxt;
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-back arbitration onto the register file port plus busy scoreboard
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_addr,
  input  logic [ADDR_W-1:0]         chk_addr_a,
  input  logic [ADDR_W-1:0]         chk_addr_b,
  output logic                      hazard_a,
  output logic                      hazard_b,
  output logic [2**ADDR_W-1:0]      busy,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic                      reg_we
);
  localparam int NREG = 2**ADDR_W;

  logic [NUM_SRC-1:0] gnt;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               we_q;
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_nxt;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .req     (src_valid),
    .gnt     (gnt),
    .advance (xfer)
  );

  assign src_ready = gnt;
  assign xfer      = |(src_valid & gnt);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr = src_addr[i*ADDR_W +: ADDR_W];
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to register 0 are accepted and dropped here rather than stalling the source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr <= '0;
      wdata <= '0;
      we_q  <= 1'b0;
    end else if (run) begin
      we_q <= xfer && (sel_addr != '0);
      if (xfer) begin
        waddr <= sel_addr;
        wdata <= sel_data;
      end
    end
  end

  assign reg_we = we_q & run;

  // Clear first so a same-edge claim of the retiring register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (reg_we) busy_nxt[waddr] = 1'b0;
    if (claim_valid && claim_addr != '0) busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else if (run) begin
      busy_q <= busy_nxt;
    end
  end

  assign busy     = busy_q;
  assign hazard_a = busy_q[chk_addr_a];
  assign hazard_b = busy_q[chk_addr_b];
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed and randomized bench against a behavioural write-back model
module tb_regfile_wb_ctrl;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS-1:0]    src_ready;
  logic [NS*AW-1:0] src_addr = '0;
  logic [NS*DW-1:0] src_data = '0;
  logic             claim_valid = 1'b0;
  logic [AW-1:0]    claim_addr = '0;
  logic [AW-1:0]    chk_addr_a = '0;
  logic [AW-1:0]    chk_addr_b = '0;
  logic             hazard_a, hazard_b;
  logic [31:0]      busy;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             reg_we;

  int n_cmp = 0;
  int n_fail = 0;

  regfile_wb_ctrl #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .run(run),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .busy(busy), .waddr(waddr), .wdata(wdata), .reg_we(reg_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_addr[i*AW +: AW] = a;
    src_data[i*DW +: DW] = d;
  endtask

  // Behavioural model: pointer as an integer, scoreboard as a flag per register.
  int          m_ptr = 0, nx_ptr = 0;
  logic        m_we = 0, nx_we = 0;
  logic [4:0]  m_waddr = 0, nx_waddr = 0;
  logic [31:0] m_wdata = 0, nx_wdata = 0;
  logic [31:0] m_busy = 0, nx_busy = 0;

  always @(negedge clk) begin
    int g;
    logic [NS-1:0] exp_ready;
    logic exp_we;
    g = -1;
    exp_ready = '0;
    if (run) begin
      for (int k = 0; k < NS; k++) begin
        if (g < 0 && src_valid[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_we = m_we && run;
    check("src_ready", 64'(src_ready), 64'(exp_ready));
    check("reg_we", 64'(reg_we), 64'(exp_we));
    check("waddr", 64'(waddr), 64'(m_waddr));
    check("wdata", 64'(wdata), 64'(m_wdata));
    check("busy", 64'(busy), 64'(m_busy));
    check("hazard_a", 64'(hazard_a), 64'(m_busy[chk_addr_a]));
    check("hazard_b", 64'(hazard_b), 64'(m_busy[chk_addr_b]));
    nx_ptr = m_ptr; nx_we = m_we; nx_waddr = m_waddr; nx_wdata = m_wdata; nx_busy = m_busy;
    if (run) begin
      if (exp_we) nx_busy[m_waddr] = 1'b0;
      if (claim_valid && claim_addr != 0) nx_busy[claim_addr] = 1'b1;
      if (g >= 0) begin
        nx_ptr   = (g + 1) % NS;
        nx_waddr = src_addr[g*AW +: AW];
        nx_wdata = src_data[g*DW +: DW];
        nx_we    = (nx_waddr != 0);
      end else begin
        nx_we = 1'b0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr <= 0; m_we <= 0; m_waddr <= 0; m_wdata <= 0; m_busy <= 0;
    end else begin
      m_ptr <= nx_ptr; m_we <= nx_we; m_waddr <= nx_waddr; m_wdata <= nx_wdata; m_busy <= nx_busy;
    end
  end

  initial begin
    repeat (2) step();
    reset = 1'b0;
    run = 1'b1;
    chk_addr_a = 5'd7;
    chk_addr_b = 5'd9;
    step();
    check("idle_we", 64'(reg_we), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(src_ready), 64'd0);
    check("idle_haz", 64'({hazard_a, hazard_b}), 64'd0);

    set_src(1, 5'd5, 32'hDEADBEEF);
    src_valid = 3'b010;
    #1 check("single_ready", 64'(src_ready), 64'b010);
    step();
    src_valid = '0;
    check("single_we", 64'(reg_we), 64'd1);
    check("single_waddr", 64'(waddr), 64'd5);
    check("single_wdata", 64'(wdata), 64'hDEADBEEF);
    step();
    check("single_we_off", 64'(reg_we), 64'd0);

    set_src(2, 5'd0, 32'h55);
    src_valid = 3'b100;
    #1 check("a0_ready", 64'(src_ready), 64'b100);
    step();
    src_valid = '0;
    check("a0_we", 64'(reg_we), 64'd0);

    set_src(0, 5'd1, 32'h100);
    set_src(1, 5'd2, 32'h101);
    set_src(2, 5'd3, 32'h102);
    src_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 check("rr_ready", 64'(src_ready), 64'(1 << (c % 3)));
      step();
      check("rr_we", 64'(reg_we), 64'd1);
      check("rr_waddr", 64'(waddr), 64'((c % 3) + 1));
    end
    src_valid = '0;

    claim_valid = 1'b1;
    claim_addr = 5'd7;
    #1 check("claim_haz_pre", 64'(hazard_a), 64'd0);
    step();
    claim_valid = 1'b0;
    check("claim_haz", 64'(hazard_a), 64'd1);
    check("claim_busy", 64'(busy), 64'h80);
    set_src(0, 5'd7, 32'hA7);
    src_valid = 3'b001;
    step();
    src_valid = '0;
    check("clr_we", 64'(reg_we), 64'd1);
    check("clr_haz_we", 64'(hazard_a), 64'd1);
    step();
    check("clr_haz_after", 64'(hazard_a), 64'd0);

    claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
    src_valid = 3'b001;
    step();
    src_valid = '0;
    claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
    check("claim_wins", 64'(busy), 64'h80);
    src_valid = 3'b001;
    step();
    src_valid = '0;
    step();
    check("reclear", 64'(busy), 64'd0);

    claim_valid = 1'b1;
    claim_addr = 5'd0;
    step();
    claim_valid = 1'b0;
    check("claim0", 64'(busy), 64'd0);

    claim_valid = 1'b1;
    claim_addr = 5'd9;
    step();
    claim_valid = 1'b0;
    set_src(0, 5'd9, 32'h99);
    src_valid = 3'b001;
    step();
    run = 1'b0;
    src_valid = 3'b111;
    claim_valid = 1'b1;
    claim_addr = 5'd10;
    #1 check("frz_ready", 64'(src_ready), 64'd0);
    check("frz_we", 64'(reg_we), 64'd0);
    step();
    step();
    check("frz_busy", 64'(busy), 64'h200);
    run = 1'b1;
    src_valid = '0;
    claim_valid = 1'b0;
    #1 check("thaw_we", 64'(reg_we), 64'd1);
    check("thaw_waddr", 64'(waddr), 64'd9);
    step();
    check("thaw_busy", 64'(busy), 64'd0);

    claim_valid = 1'b1;
    claim_addr = 5'd11;
    step();
    claim_valid = 1'b0;
    set_src(0, 5'd11, 32'hB);
    src_valid = 3'b001;
    step();
    src_valid = '0;
    check("pre_rst_we", 64'(reg_we), 64'd1);
    #2 reset = 1'b1;
    #1 check("rst_we", 64'(reg_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    reset = 1'b0;
    step();

    for (int c = 0; c < 1500; c++) begin
      src_valid = NS'($urandom);
      for (int i = 0; i < NS; i++) set_src(i, 5'($urandom_range(0, 12)), $urandom);
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_addr  = 5'($urandom_range(0, 12));
      chk_addr_a  = 5'($urandom_range(0, 12));
      chk_addr_b  = 5'($urandom_range(0, 12));
      run         = ($urandom_range(0, 7) != 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
